// File: rtl/led_frame_tx.sv
// Idle-high serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Accepts a word in IDLE and holds each bit on tx_out for CLKS_PER_BIT cycles. A start request while busy is dropped.
module led_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 6,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [7:0]      CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              bit_end;
    logic [DATA_W-1:0] shift_nx;

    assign bit_end  = (cnt_q == CNT_LAST);
    assign shift_nx = shift_q >> 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (start) begin
                    shift_d = data;
                    par_d   = ^data;
                    bit_d   = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // tx must present the next bit on the same edge the register shifts
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_nx;
                        tx_d    = shift_nx[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_led_frame_tx.sv
// Bench for led_frame_tx: three instances (default, parity at 2 clocks/bit, 1 clock/bit) checked against a per-cycle line model.
module tb_led_frame_tx;

    logic clk;
    logic resetn;
    logic st0, st1, st2;
    logic [5:0] d0, d1, d2;
    logic tx0, tx1, tx2, b0, b1, b2, dn0, dn1, dn2;

    int checks;
    int errors;
    bit wave[$];

    led_frame_tx u0 (
        .clk(clk), .resetn(resetn), .start(st0), .data(d0),
        .tx_out(tx0), .busy(b0), .done(dn0)
    );

    led_frame_tx #(.CLKS_PER_BIT(2), .DATA_W(6), .PARITY_EN(1)) u1 (
        .clk(clk), .resetn(resetn), .start(st1), .data(d1),
        .tx_out(tx1), .busy(b1), .done(dn1)
    );

    led_frame_tx #(.CLKS_PER_BIT(1), .DATA_W(6), .PARITY_EN(0)) u2 (
        .clk(clk), .resetn(resetn), .start(st2), .data(d2),
        .tx_out(tx2), .busy(b2), .done(dn2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected line level for every cycle the frame is busy.
    task automatic build_wave(input logic [5:0] d, input int par_en, input int cpb);
        bit frame[$];
        wave.delete();
        frame.push_back(1'b0);
        for (int k = 0; k < 6; k++) frame.push_back(d[k]);
        if (par_en != 0) frame.push_back(^d);
        frame.push_back(1'b1);
        foreach (frame[k]) repeat (cpb) wave.push_back(frame[k]);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        st0 = 1'b1;
        d0 = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== 3'b100) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b want 100", i, {tx0, b0, dn0});
            end
        end
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx0, b0, dn0} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release got %b want 100", {tx0, b0, dn0});
        end
        @(posedge clk); #1 st0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx0, b0, dn0} !== 3'b010) begin
            errors++;
            $display("FAIL reset_first_start got %b want 010", {tx0, b0, dn0});
        end
        repeat (40) @(negedge clk);
        checks++;
        if ({tx0, b0, dn0} !== 3'b100) begin
            errors++;
            $display("FAIL reset_drain got %b want 100", {tx0, b0, dn0});
        end
    endtask

    task automatic test_basic();
        logic [5:0] val;
        for (int f = 0; f < 4; f++) begin
            val = (f == 0) ? 6'b101101 : 6'($urandom);
            build_wave(val, 0, 4);
            @(posedge clk); #1 st0 = 1'b1; d0 = val;
            @(posedge clk); #1 st0 = 1'b0; d0 = 6'($urandom);
            foreach (wave[i]) begin
                @(negedge clk);
                checks++;
                if ({tx0, b0, dn0} !== {wave[i], 2'b10}) begin
                    errors++;
                    $display("FAIL basic f%0d cyc %0d got %b want %b", f, i, {tx0, b0, dn0}, {wave[i], 2'b10});
                end
            end
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== 3'b101) begin
                errors++;
                $display("FAIL basic_done f%0d got %b want 101", f, {tx0, b0, dn0});
            end
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== 3'b100) begin
                errors++;
                $display("FAIL basic_idle f%0d got %b want 100", f, {tx0, b0, dn0});
            end
        end
    endtask

    task automatic test_parity();
        logic [5:0] val;
        for (int f = 0; f < 4; f++) begin
            val = (f == 0) ? 6'b000111 : 6'($urandom);
            build_wave(val, 1, 2);
            @(posedge clk); #1 st1 = 1'b1; d1 = val;
            @(posedge clk); #1 st1 = 1'b0; d1 = ~val;
            foreach (wave[i]) begin
                @(negedge clk);
                checks++;
                if ({tx1, b1, dn1} !== {wave[i], 2'b10}) begin
                    errors++;
                    $display("FAIL parity f%0d cyc %0d got %b want %b", f, i, {tx1, b1, dn1}, {wave[i], 2'b10});
                end
            end
            @(negedge clk);
            checks++;
            if ({tx1, b1, dn1} !== 3'b101) begin
                errors++;
                $display("FAIL parity_done f%0d got %b want 101", f, {tx1, b1, dn1});
            end
        end
    endtask

    task automatic test_ignore_busy();
        int dones;
        build_wave(6'b000000, 0, 4);
        @(posedge clk); #1 st0 = 1'b1; d0 = 6'b000000;
        @(posedge clk); #1 st0 = 1'b0;
        foreach (wave[i]) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== {wave[i], 2'b10}) begin
                errors++;
                $display("FAIL ignore cyc %0d got %b want %b", i, {tx0, b0, dn0}, {wave[i], 2'b10});
            end
            if (i == 9) begin st0 = 1'b1; d0 = 6'b111111; end
            if (i == 10) st0 = 1'b0;
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dn0) dones++;
            if (i > 0) begin
                checks++;
                if (b0 !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_no_refire cyc %0d busy got %b want 0", i, b0);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] val;
        val = 6'b000001;
        @(posedge clk); #1 st2 = 1'b1; d2 = val;
        @(posedge clk);
        for (int f = 0; f < 4; f++) begin
            build_wave(val, 0, 1);
            foreach (wave[i]) begin
                @(negedge clk);
                checks++;
                if ({tx2, b2, dn2} !== {wave[i], 2'b10}) begin
                    errors++;
                    $display("FAIL b2b f%0d cyc %0d got %b want %b", f, i, {tx2, b2, dn2}, {wave[i], 2'b10});
                end
            end
            @(negedge clk);
            checks++;
            if ({tx2, b2, dn2} !== 3'b101) begin
                errors++;
                $display("FAIL b2b_done f%0d got %b want 101", f, {tx2, b2, dn2});
            end
            val = 6'($urandom);
            d2 = val;
            if (f == 3) st2 = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({tx2, b2, dn2} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_stop got %b want 100", {tx2, b2, dn2});
        end
    endtask

    task automatic test_mid_reset();
        logic [5:0] val;
        val = 6'($urandom);
        build_wave(val, 0, 4);
        @(posedge clk); #1 st0 = 1'b1; d0 = val;
        @(posedge clk); #1 st0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== {wave[i], 2'b10}) begin
                errors++;
                $display("FAIL midrst_pre cyc %0d got %b want %b", i, {tx0, b0, dn0}, {wave[i], 2'b10});
            end
        end
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_abort cyc %0d got %b want 100", i, {tx0, b0, dn0});
            end
        end
        resetn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_quiet cyc %0d got %b want 100", i, {tx0, b0, dn0});
            end
        end
        val = 6'($urandom);
        build_wave(val, 0, 4);
        @(posedge clk); #1 st0 = 1'b1; d0 = val;
        @(posedge clk); #1 st0 = 1'b0;
        foreach (wave[i]) begin
            @(negedge clk);
            checks++;
            if ({tx0, b0, dn0} !== {wave[i], 2'b10}) begin
                errors++;
                $display("FAIL midrst_new cyc %0d got %b want %b", i, {tx0, b0, dn0}, {wave[i], 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({tx0, b0, dn0} !== 3'b101) begin
            errors++;
            $display("FAIL midrst_done got %b want 101", {tx0, b0, dn0});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        test_reset();
        test_basic();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
